j1_ram_loader: RTL and testbench

//  Boot sequencer and port-A arbiter for the j1 dual-port code/data RAM. It holds the j1 in reset,

---
 rtl/j1_boot_pkg.sv | 17 +
 rtl/j1_ram_loader.sv | 198 +++++++++++++++++++
 tb/tb_j1_ram_loader.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/j1_boot_pkg.sv
// Shared types for the j1 boot loader: FSM state encoding and frame constants.
package j1_boot_pkg;

  typedef enum logic [2:0] {
    ST_START,
    ST_RUN,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DAT_LO,
    ST_DAT_HI,
    ST_WRITE,
    ST_CSUM
  } state_t;

  localparam int BYTES_PER_WORD = 2;

endpackage

// File: rtl/j1_ram_loader.sv
// Boot sequencer for the j1: holds the CPU in reset while a checksummed image is
// streamed into RAM port A, then hands port A back to the instruction fetch path.
module j1_ram_loader
  import j1_boot_pkg::*;
#(
  parameter int LOG2ABITS = 11,
  parameter int DWIDTH    = 16,
  parameter int TIMEOUT   = 65535,
  parameter int AUTOBOOT  = 1
) (
  input  logic                 clk,
  input  logic                 resetq,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 rx_ready,
  input  logic                 boot_req,
  input  logic [LOG2ABITS-1:0] j1_code_addr,
  input  logic                 j1_mem_wr,
  output logic [LOG2ABITS-1:0] ram_addra,
  output logic                 ram_wea,
  output logic [DWIDTH-1:0]    ram_writea,
  output logic                 ram_web,
  output logic                 cpu_reset,
  output logic                 loading,
  output logic                 done,
  output logic                 error
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int CW = LOG2ABITS + 1;
  localparam logic [31:0] DEPTH = 32'(1) << LOG2ABITS;

  state_t                      state_q, state_d;
  logic [7:0]                  len_lo_q, len_lo_d;
  logic [7:0]                  lo_q, lo_d;
  logic [7:0]                  hi_q, hi_d;
  logic [CW-1:0]               addr_q, addr_d;
  logic [CW-1:0]               rem_q, rem_d;
  logic [7:0]                  csum_q, csum_d;
  logic [IW-1:0]               idle_q, idle_d;
  logic                        cpu_reset_q, cpu_reset_d;
  logic                        rx_ready_q, rx_ready_d;
  logic                        loading_q, loading_d;
  logic                        ram_wea_q, ram_wea_d;
  logic                        done_q, done_d;
  logic                        error_q, error_d;

  logic                        accept;
  logic                        armed;
  logic [15:0]                 len_word;
  logic [8*BYTES_PER_WORD-1:0] word;

  assign accept   = rx_valid & rx_ready_q;
  assign armed    = (state_q == ST_LEN_HI) || (state_q == ST_DAT_LO) ||
                    (state_q == ST_DAT_HI) || (state_q == ST_CSUM);
  assign len_word = {rx_data, len_lo_q};
  assign word     = {hi_q, lo_q};

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    csum_d   = csum_q;
    done_d   = done_q;
    error_d  = error_q;
    idle_d   = (accept || !armed) ? '0 : idle_q + 1'b1;

    case (state_q)
      ST_START: state_d = (AUTOBOOT != 0) ? ST_RUN : ST_LEN_LO;
      ST_RUN: begin
        if (boot_req) begin
          state_d = ST_LEN_LO;
          done_d  = 1'b0;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_lo_d = rx_data;
          csum_d   = rx_data;
          error_d  = 1'b0;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          csum_d = csum_q + rx_data;
          if (len_word == 16'd0) begin
            state_d = ST_CSUM;
          end else if ({16'd0, len_word} > DEPTH) begin
            error_d = 1'b1;
            state_d = ST_LEN_LO;
          end else begin
            addr_d  = '0;
            rem_d   = CW'(len_word);
            state_d = ST_DAT_LO;
          end
        end
      end
      ST_DAT_LO: begin
        if (accept) begin
          lo_d    = rx_data;
          csum_d  = csum_q + rx_data;
          state_d = ST_DAT_HI;
        end
      end
      ST_DAT_HI: begin
        if (accept) begin
          hi_d    = rx_data;
          csum_d  = csum_q + rx_data;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        state_d = (rem_q == CW'(1)) ? ST_CSUM : ST_DAT_LO;
      end
      ST_CSUM: begin
        if (accept) begin
          if (rx_data == csum_q) begin
            done_d  = 1'b1;
            state_d = ST_RUN;
          end else begin
            error_d = 1'b1;
            state_d = ST_LEN_LO;
          end
        end
      end
      default: state_d = ST_START;
    endcase

    // A stalled host mid-frame abandons the frame; LEN_LO is never armed.
    if (armed && !accept && (idle_q == IW'(TIMEOUT - 1))) begin
      error_d = 1'b1;
      state_d = ST_LEN_LO;
      idle_d  = '0;
    end

    cpu_reset_d = (state_d != ST_RUN);
    ram_wea_d   = (state_d == ST_WRITE);
    rx_ready_d  = (state_d == ST_LEN_LO) || (state_d == ST_LEN_HI) ||
                  (state_d == ST_DAT_LO) || (state_d == ST_DAT_HI) ||
                  (state_d == ST_CSUM);
    loading_d   = rx_ready_d || ram_wea_d;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q     <= ST_START;
      len_lo_q    <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      csum_q      <= '0;
      idle_q      <= '0;
      cpu_reset_q <= 1'b1;
      rx_ready_q  <= 1'b0;
      loading_q   <= 1'b0;
      ram_wea_q   <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      csum_q      <= csum_d;
      idle_q      <= idle_d;
      cpu_reset_q <= cpu_reset_d;
      rx_ready_q  <= rx_ready_d;
      loading_q   <= loading_d;
      ram_wea_q   <= ram_wea_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // The counter's top bit only exists so a full-depth load ends without wrapping.
  logic addr_top_unused;
  assign addr_top_unused = addr_q[CW-1];

  assign ram_addra  = (state_q == ST_RUN) ? j1_code_addr : addr_q[LOG2ABITS-1:0];
  assign ram_writea = DWIDTH'(word);
  assign ram_web    = j1_mem_wr & ~cpu_reset_q;
  assign rx_ready   = rx_ready_q;
  assign ram_wea    = ram_wea_q;
  assign cpu_reset  = cpu_reset_q;
  assign loading    = loading_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_j1_ram_loader.sv
// Randomised frame-level bench for j1_ram_loader against a byte-stream reference model.
module tb_j1_ram_loader;

  localparam int LA    = 11;
  localparam int DW    = 16;
  localparam int TO    = 200;
  localparam int DEPTH = 1 << LA;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          addr;
    logic [15:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          resetq = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          boot_req = 1'b0;
  logic [LA-1:0] j1_code_addr = '0;
  logic          j1_mem_wr = 1'b0;
  logic          rx_ready;
  logic [LA-1:0] ram_addra;
  logic          ram_wea;
  logic [DW-1:0] ram_writea;
  logic          ram_web;
  logic          cpu_reset;
  logic          loading;
  logic          done;
  logic          error;

  int            checks = 0;
  int            errors = 0;
  int            wr_count = 0;
  bit            fixed_addr = 1'b1;
  bit            in_run = 1'b0;
  wr_t           exp_q[$];
  logic [15:0]   shadow[0:DEPTH-1];
  logic [15:0]   exp_ram[0:DEPTH-1];

  j1_ram_loader #(.LOG2ABITS(LA), .DWIDTH(DW), .TIMEOUT(TO), .AUTOBOOT(1)) dut (
    .clk(clk), .resetq(resetq), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .boot_req(boot_req), .j1_code_addr(j1_code_addr),
    .j1_mem_wr(j1_mem_wr), .ram_addra(ram_addra), .ram_wea(ram_wea),
    .ram_writea(ram_writea), .ram_web(ram_web), .cpu_reset(cpu_reset),
    .loading(loading), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Background j1 activity: random fetch address and data-port write strobes.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (fixed_addr) begin
        j1_code_addr = LA'(12'h123);
        j1_mem_wr    = 1'b1;
      end else begin
        j1_code_addr = LA'($urandom);
        j1_mem_wr    = 1'($urandom);
      end
    end
  end

  // Per-cycle compare process: port-A ownership rules and the expected write stream.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (resetq) begin
        chk("ram_web", ram_web, j1_mem_wr & ~cpu_reset);
        if (!cpu_reset) begin
          chk("run_addra", ram_addra, j1_code_addr);
          chk("run_rx_ready", rx_ready, 0);
          chk("run_wea", ram_wea, 0);
          chk("run_loading", loading, 0);
        end
        if (ram_wea) begin
          wr_count++;
          chk("write_rx_ready", rx_ready, 0);
          chk("write_loading", loading, 1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=addr %0h data %0h required=no write",
                     ram_addra, ram_writea);
          end else begin
            e = exp_q.pop_front();
            chk("write_addr", ram_addra, e.addr);
            chk("write_data", ram_writea, e.data);
          end
          shadow[ram_addra] = ram_writea;
        end
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rx_ready_wait", rx_ready, 1);
    if (rx_ready) begin
      chk("load_cpu_reset", cpu_reset, 1);
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic start_load();
    if (in_run) begin
      boot_req = 1'b1;
      @(posedge clk);
      #1;
      boot_req = 1'b0;
      chk("boot_cpu_reset", cpu_reset, 1);
      chk("boot_done_clear", done, 0);
      chk("boot_loading", loading, 1);
      in_run = 1'b0;
    end
  endtask

  // Reference model: interpret the frame as the host sees it, then send and check outcome.
  task automatic run_frame(input bq_t f);
    int          n;
    int          used;
    logic [7:0]  sum;
    bit          ok;
    bit          oversize;
    n        = int'({f[1], f[0]});
    oversize = (n > DEPTH);
    used     = oversize ? 2 : 2 * n + 3;
    if (!oversize) begin
      for (int w = 0; w < n; w++) begin
        exp_q.push_back('{w, {f[3 + 2 * w], f[2 + 2 * w]}});
        exp_ram[w] = {f[3 + 2 * w], f[2 + 2 * w]};
      end
    end
    sum = 8'h00;
    for (int i = 0; i < used - 1; i++) sum = sum + f[i];
    ok = !oversize && (f[used - 1] == sum);
    start_load();
    for (int i = 0; i < used; i++) begin
      send_byte(f[i]);
      if (i == 0) chk("error_clear_on_len", error, 0);
    end
    chk("frame_done", done, ok);
    chk("frame_error", error, !ok);
    chk("frame_cpu_reset", cpu_reset, !ok);
    chk("frame_rx_ready", rx_ready, !ok);
    chk("frame_writes_left", exp_q.size(), 0);
    in_run = ok;
  endtask

  initial begin
    bq_t         f;
    int          n;
    int          k;
    int          wr_before;
    logic [7:0]  s;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_wea", ram_wea, 0);
    chk("rst_loading", loading, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    @(negedge clk);
    resetq = 1'b1;
    @(posedge clk);
    #1;
    chk("start_cpu_reset", cpu_reset, 0);
    chk("autoboot_addra", ram_addra, 32'h123);
    @(posedge clk);
    #1;
    chk("run_cpu_reset", cpu_reset, 0);
    in_run     = 1'b1;
    fixed_addr = 1'b0;

    f = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'hC0};
    run_frame(f);
    chk("lit_word0", shadow[0], 32'h1234);
    chk("lit_word1", shadow[1], 32'hABCD);
    chk("lit_done", done, 1);

    f = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'hC1};
    run_frame(f);
    chk("lit_bad_error", error, 1);
    f = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'hC0};
    run_frame(f);
    chk("lit_retry_done", done, 1);

    f = '{8'h01, 8'h08};
    run_frame(f);
    chk("lit_oversize_error", error, 1);
    f = '{8'h00, 8'h00, 8'h00};
    run_frame(f);
    chk("lit_empty_done", done, 1);

    for (int t = 0; t < 14; t++) begin
      f = {};
      if ($urandom_range(0, 7) == 0) n = DEPTH + 1 + $urandom_range(0, 3000);
      else n = $urandom_range(0, 16);
      f.push_back(n[7:0]);
      f.push_back(n[15:8]);
      if (n <= DEPTH) begin
        for (int i = 0; i < 2 * n; i++) f.push_back(8'($urandom));
        s = 8'h00;
        foreach (f[i]) s = s + f[i];
        if ($urandom_range(0, 3) == 0) s = s + 8'($urandom_range(1, 255));
        f.push_back(s);
      end
      run_frame(f);
    end

    f = '{8'h00, 8'h08};
    for (int i = 0; i < 2 * DEPTH; i++) f.push_back(8'($urandom));
    s = 8'h00;
    foreach (f[i]) s = s + f[i];
    f.push_back(s);
    run_frame(f);
    chk("fill_done", done, 1);
    chk("fill_last", shadow[DEPTH - 1], exp_ram[DEPTH - 1]);

    start_load();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h34);
    k = 0;
    while (!error && k < TO + 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("timeout_cycles", k, TO);
    chk("timeout_rx_ready", rx_ready, 1);
    repeat (3 * TO) @(posedge clk);
    #1;
    chk("lenlo_unarmed_error", error, 1);
    chk("lenlo_unarmed_ready", rx_ready, 1);
    f = '{8'h00, 8'h00, 8'h00};
    run_frame(f);

    wr_before = wr_count;
    start_load();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h34);
    @(negedge clk);
    resetq = 1'b0;
    #1;
    chk("mid_rst_cpu_reset", cpu_reset, 1);
    chk("mid_rst_rx_ready", rx_ready, 0);
    chk("mid_rst_wea", ram_wea, 0);
    chk("mid_rst_loading", loading, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_error", error, 0);
    rx_valid = 1'b1;
    rx_data  = 8'h12;
    repeat (3) @(negedge clk);
    resetq = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    chk("post_rst_cpu_reset", cpu_reset, 0);
    in_run = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("abandoned_no_write", wr_count, wr_before);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
